// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and sequencer in front of a single-port RAM.
// Data has priority over fetch; a saturating streak counter bounds fetch starvation.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4     // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // Handshake: a requester raises *_req_i with a stable payload and holds it until
  // the one-cycle *_gnt_o pulse; the grant is the acceptance. The result comes back
  // as a one-cycle *_rvalid_o pulse two cycles later with no back-pressure.
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  input  logic [3:0]            dm_wr_mask_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wr_mask_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  // Debug view: state encoding 0=IDLE, 1=ACCESS, 2=RESP; current streak count.
  output logic [1:0]            dbg_state_o,
  output logic [3:0]            dbg_streak_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [3:0]            r_streak;
  logic [3:0]            w_next_streak;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_mask;
  logic                  r_owner_dm;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;

  logic w_arb_en;
  logic w_streak_full;
  logic w_if_gnt;
  logic w_dm_gnt;
  logic w_any_gnt;
  logic w_in_access;

  // Arbitration runs whenever the RAM is not busy (IDLE or RESP).
  always_comb begin
    w_in_access   = (r_state == ST_ACCESS);
    w_arb_en      = !w_in_access;
    w_streak_full = (r_streak >= STREAK_MAX);
    w_dm_gnt      = w_arb_en && dm_req_i && !(if_req_i && w_streak_full);
    w_if_gnt      = w_arb_en && if_req_i && !w_dm_gnt;
    w_any_gnt     = w_if_gnt || w_dm_gnt;
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_ACCESS: w_next_state = ST_RESP;
      default:   w_next_state = w_any_gnt ? ST_ACCESS : ST_IDLE;
    endcase
  end

  // Streak counts data grants taken while fetch was waiting.
  always_comb begin
    w_next_streak = r_streak;
    if (w_if_gnt) begin
      w_next_streak = 4'd0;
    end else if (w_dm_gnt) begin
      if (!if_req_i) begin
        w_next_streak = 4'd0;
      end else if (w_streak_full) begin
        w_next_streak = STREAK_MAX;
      end else begin
        w_next_streak = r_streak + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_streak   <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= 4'd0;
      r_owner_dm <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state  <= w_next_state;
      r_streak <= w_next_streak;
      if (w_dm_gnt) begin
        r_addr     <= dm_addr_i;
        r_wdata    <= dm_wdata_i;
        r_mask     <= dm_wr_mask_i;
        r_owner_dm <= 1'b1;
      end else if (w_if_gnt) begin
        r_addr     <= if_addr_i;
        r_wdata    <= '0;
        r_mask     <= 4'd0;
        r_owner_dm <= 1'b0;
      end
      // Each owner keeps its own response so the other's rdata holds across accesses.
      if (w_in_access) begin
        if (r_owner_dm) begin
          r_dm_rdata <= (r_mask == 4'd0) ? mem_rdata_i : '0;
        end else begin
          r_if_rdata <= mem_rdata_i;
        end
      end
    end
  end

  assign if_gnt_o      = w_if_gnt;
  assign dm_gnt_o      = w_dm_gnt;
  assign mem_en_o      = w_in_access;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign mem_wr_mask_o = r_mask;
  assign if_rvalid_o   = (r_state == ST_RESP) && !r_owner_dm;
  assign dm_rvalid_o   = (r_state == ST_RESP) && r_owner_dm;
  assign if_rdata_o    = r_if_rdata;
  assign dm_rdata_o    = r_dm_rdata;
  assign dbg_state_o   = r_state;
  assign dbg_streak_o  = r_streak;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, directed scenarios and a randomized phase,
// all checked against a transaction-level reference memory and arbitration model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXS = 4;
  localparam logic [3:0] MAXS4 = 4'(MAXS);
  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic [3:0]    dm_wr_mask_i = 4'd0;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_wr_mask_o;
  logic [DW-1:0] mem_rdata_i;
  logic [1:0]    dbg_state_o;
  logic [3:0]    dbg_streak_o;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_wr_mask_i(dm_wr_mask_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wr_mask_o(mem_wr_mask_o), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o), .dbg_streak_o(dbg_streak_o)
  );

  // ---------------- RAM model (combinational read, byte-masked write) ----------------
  logic [31:0] ram [0:63];
  assign mem_rdata_i = ram[mem_addr_o[7:2]];
  always @(posedge clk) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_mask_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0]   ref_mem [0:63];
  logic [DW-1:0] exp_q[$];
  logic          own_q[$];
  logic          m_acc_v = 1'b0;
  logic          m_acc_dm = 1'b0;
  logic          m_resp_v = 1'b0;
  logic          m_resp_dm = 1'b0;
  logic [AW-1:0] m_acc_addr = '0;
  logic [DW-1:0] m_acc_wdata = '0;
  logic [3:0]    m_acc_mask = 4'd0;
  logic [3:0]    m_streak = 4'd0;
  logic          m_exp_if;
  logic          m_exp_dm;
  logic [DW-1:0] m_d;
  logic          m_own;
  logic [5:0]    m_idx;

  always @(negedge clk) begin
    if (!reset_n) begin
      check_eq("rst_if_gnt", 64'(if_gnt_o), 64'd0);
      check_eq("rst_dm_gnt", 64'(dm_gnt_o), 64'd0);
      check_eq("rst_rvalid", 64'({if_rvalid_o, dm_rvalid_o}), 64'd0);
      check_eq("rst_mem_en", 64'(mem_en_o), 64'd0);
      check_eq("rst_mem_bus", {mem_addr_o, mem_wdata_o} | 64'(mem_wr_mask_o), 64'd0);
      check_eq("rst_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
      check_eq("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
      check_eq("rst_streak", 64'(dbg_streak_o), 64'd0);
      m_acc_v = 1'b0;
      m_resp_v = 1'b0;
      m_streak = 4'd0;
      exp_q.delete();
      own_q.delete();
    end else begin
      // RAM access happens exactly one cycle after a grant, with the granted payload.
      check_eq("mem_en", 64'(mem_en_o), 64'(m_acc_v));
      if (m_acc_v) begin
        check_eq("mem_addr", 64'(mem_addr_o), 64'(m_acc_addr));
        check_eq("mem_wdata", 64'(mem_wdata_o), 64'(m_acc_wdata));
        check_eq("mem_mask", 64'(mem_wr_mask_o), 64'(m_acc_mask));
      end
      check_eq("if_rvalid", 64'(if_rvalid_o), 64'(m_resp_v && !m_resp_dm));
      check_eq("dm_rvalid", 64'(dm_rvalid_o), 64'(m_resp_v && m_resp_dm));
      if (m_resp_v) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          m_d = exp_q.pop_front();
          m_own = own_q.pop_front();
          if (m_own) check_eq("dm_rdata", 64'(dm_rdata_o), 64'(m_d));
          else       check_eq("if_rdata", 64'(if_rdata_o), 64'(m_d));
        end
      end
      // Expected winner from the priority rules; no grant while an access is in flight.
      m_exp_dm = !m_acc_v && dm_req_i && !(if_req_i && m_streak == MAXS4);
      m_exp_if = !m_acc_v && if_req_i && !m_exp_dm;
      check_eq("if_gnt", 64'(if_gnt_o), 64'(m_exp_if));
      check_eq("dm_gnt", 64'(dm_gnt_o), 64'(m_exp_dm));
      check_eq("streak", 64'(dbg_streak_o), 64'(m_streak));
      m_resp_v = m_acc_v;
      m_resp_dm = m_acc_dm;
      m_acc_v = m_exp_dm || m_exp_if;
      if (m_exp_dm) begin
        m_acc_dm = 1'b1;
        m_acc_addr = dm_addr_i;
        m_acc_wdata = dm_wdata_i;
        m_acc_mask = dm_wr_mask_i;
        m_idx = dm_addr_i[7:2];
        if (dm_wr_mask_i == 4'd0) begin
          exp_q.push_back(ref_mem[m_idx]);
        end else begin
          for (int b = 0; b < 4; b++)
            if (dm_wr_mask_i[b]) ref_mem[m_idx][8*b +: 8] = dm_wdata_i[8*b +: 8];
          exp_q.push_back('0);
        end
        own_q.push_back(1'b1);
        if (!if_req_i) m_streak = 4'd0;
        else if (m_streak != MAXS4) m_streak = m_streak + 4'd1;
      end else if (m_exp_if) begin
        m_acc_dm = 1'b0;
        m_acc_addr = if_addr_i;
        m_acc_wdata = '0;
        m_acc_mask = 4'd0;
        exp_q.push_back(ref_mem[if_addr_i[7:2]]);
        own_q.push_back(1'b0);
        m_streak = 4'd0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_access(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [3:0] m, output logic [DW-1:0] rd);
    bit got;
    tick();
    dm_req_i = 1'b1; dm_addr_i = a; dm_wdata_i = wd; dm_wr_mask_i = m;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dm_gnt_o) begin got = 1; break; end
    end
    check_eq("dm_gnt_seen", 64'(got), 64'd1);
    tick();
    dm_req_i = 1'b0;
    got = 0;
    rd = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (dm_rvalid_o) begin rd = dm_rdata_o; got = 1; break; end
    end
    check_eq("dm_rvalid_seen", 64'(got), 64'd1);
  endtask

  task automatic if_access(input logic [AW-1:0] a, output logic [DW-1:0] rd);
    bit got;
    tick();
    if_req_i = 1'b1; if_addr_i = a;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if_gnt_o) begin got = 1; break; end
    end
    check_eq("if_gnt_seen", 64'(got), 64'd1);
    tick();
    if_req_i = 1'b0;
    got = 0;
    rd = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if_rvalid_o) begin rd = if_rdata_o; got = 1; break; end
    end
    check_eq("if_rvalid_seen", 64'(got), 64'd1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return {24'h0, 8'($urandom_range(0, 255))};
  endfunction

  // ---------------- stimulus ----------------
  logic [DW-1:0] rd;
  logic          ig;
  logic          dg;
  int            last;
  int            ngnt;
  int            nrv;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram[8] = 32'hDEADBEEF;
    ref_mem[8] = 32'hDEADBEEF;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Single fetch: grant at T, RAM enable with read mask at T+1, data at T+2.
    if_req_i = 1'b1; if_addr_i = 32'h20;
    @(negedge clk); check_eq("sf_gnt_T", 64'(if_gnt_o), 64'd1);
    tick(); if_req_i = 1'b0;
    @(negedge clk);
    check_eq("sf_en_T1", 64'(mem_en_o), 64'd1);
    check_eq("sf_mask_T1", 64'(mem_wr_mask_o), 64'd0);
    @(negedge clk);
    check_eq("sf_rvalid_T2", 64'(if_rvalid_o), 64'd1);
    check_eq("sf_rdata_T2", 64'(if_rdata_o), 64'hDEADBEEF);

    // Masked write then read back.
    dm_access(32'h20, 32'hDEADBEEF, 4'b1111, rd);
    check_eq("mw_w1_rdata", 64'(rd), 64'd0);
    dm_access(32'h20, 32'h00001234, 4'b0011, rd);
    check_eq("mw_w2_rdata", 64'(rd), 64'd0);
    dm_access(32'h20, 32'h0, 4'b0000, rd);
    check_eq("mw_read", 64'(rd), 64'hDEAD1234);

    // Simultaneous requests: data first, fetch granted in the RESP cycle.
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'h04; dm_wr_mask_i = 4'd0;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    @(negedge clk);
    check_eq("sim_dm_first", 64'({dm_gnt_o, if_gnt_o}), 64'b10);
    tick(); dm_req_i = 1'b0;
    @(negedge clk); check_eq("sim_if_wait", 64'(if_gnt_o), 64'd0);
    @(negedge clk); check_eq("sim_if_gnt", 64'(if_gnt_o), 64'd1);
    tick(); if_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("sim_if_rvalid", 64'(if_rvalid_o), 64'd1);
    check_eq("sim_if_rdata", 64'(if_rdata_o), 64'hDEAD1234);

    // Starvation bound: DM x4, IF, DM x4, IF with grants two cycles apart.
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'h20; dm_wr_mask_i = 4'd0;
    if_req_i = 1'b1; if_addr_i = 32'h24;
    last = -1; ngnt = 0;
    for (int c = 0; c < 40 && ngnt < 10; c++) begin
      @(negedge clk);
      if (if_gnt_o || dm_gnt_o) begin
        check_eq($sformatf("stv_owner_%0d", ngnt), 64'(if_gnt_o), 64'((ngnt % 5) == 4));
        if (last >= 0) check_eq("stv_gap", 64'(c - last), 64'd2);
        last = c;
        ngnt++;
      end
    end
    check_eq("stv_count", 64'(ngnt), 64'd10);
    tick(); dm_req_i = 1'b0; if_req_i = 1'b0;
    repeat (3) tick();

    // Reset during ACCESS of a DM read: outputs clear at once, no late rvalid.
    dm_req_i = 1'b1; dm_addr_i = 32'h20; dm_wr_mask_i = 4'd0;
    @(negedge clk); check_eq("rma_gnt", 64'(dm_gnt_o), 64'd1);
    tick(); dm_req_i = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rma_en_drop", 64'(mem_en_o), 64'd0);
    check_eq("rma_outs_drop", 64'({dm_gnt_o, if_gnt_o, dm_rvalid_o, if_rvalid_o}), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    nrv = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (dm_rvalid_o) nrv++;
    end
    check_eq("rma_no_rvalid", 64'(nrv), 64'd0);
    dm_access(32'h20, 32'h0, 4'd0, rd);
    check_eq("rma_next_read", 64'(rd), 64'hDEAD1234);

    // Streak builds on a contended data grant and clears after fetch-only traffic.
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'h10; dm_wr_mask_i = 4'd0;
    if_req_i = 1'b1; if_addr_i = 32'h14;
    @(negedge clk); check_eq("stk_dm_gnt", 64'(dm_gnt_o), 64'd1);
    tick(); dm_req_i = 1'b0;
    @(negedge clk); check_eq("stk_one", 64'(dbg_streak_o), 64'd1);
    @(negedge clk); check_eq("stk_if_gnt", 64'(if_gnt_o), 64'd1);
    tick(); if_req_i = 1'b0;
    @(negedge clk); check_eq("stk_clear", 64'(dbg_streak_o), 64'd0);
    if_access(32'h20, rd);
    check_eq("fo_rdata", 64'(rd), 64'hDEAD1234);
    if_access(32'h04, rd);
    check_eq("fo_streak", 64'(dbg_streak_o), 64'd0);
    tick();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_eq("idle_en", 64'(mem_en_o), 64'd0);
      check_eq("idle_state", 64'(dbg_state_o), 64'(ST_IDLE));
    end

    // Randomized traffic; the last 20 cycles only let pending requests finish.
    for (int c = 0; c < 820; c++) begin
      @(negedge clk);
      ig = if_gnt_o;
      dg = dm_gnt_o;
      tick();
      if (!if_req_i || ig) begin
        if (c < 800 && $urandom_range(0, 2) != 0) begin
          if_req_i = 1'b1;
          if_addr_i = rand_addr();
        end else begin
          if_req_i = 1'b0;
        end
      end
      if (!dm_req_i || dg) begin
        if (c < 800 && $urandom_range(0, 2) != 0) begin
          dm_req_i = 1'b1;
          dm_addr_i = rand_addr();
          dm_wdata_i = $urandom;
          dm_wr_mask_i = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end else begin
          dm_req_i = 1'b0;
        end
      end
    end
    repeat (4) tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
